// File: rtl/adi2axis_burst_sched.sv
// Burst sequencer for the adi2axis capture converter: arms, triggers and paces
// a programmed number of fixed-length DMA bursts, with trigger wait, gap and timeout.
module adi2axis_burst_sched #(
    parameter int BYTES_PER_BEAT = 8,
    parameter int CNT_W          = 16,
    parameter int GAP_W          = 16,
    parameter int TO_W           = 24
) (
    input  logic             AXIS_ACLK,
    input  logic             AXIS_ARESET,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [31:0]      cfg_burst_bytes,
    input  logic [CNT_W-1:0] cfg_num_bursts,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             cfg_ext_trig_en,
    input  logic             ext_trig,
    output logic [31:0]      conv_ctrl,
    output logic [31:0]      conv_num_bytes,
    output logic             conv_trig,
    input  logic [31:0]      conv_stat,
    input  logic             conv_ovf,
    output logic             busy,
    output logic             run_done,
    output logic             err_cfg,
    output logic             err_timeout,
    output logic [CNT_W-1:0] burst_cnt,
    output logic [15:0]      ovf_cnt
);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, RUN, GAP, DONE} state_t;

    state_t           state;
    logic             arm_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [CNT_W-1:0] num_bursts_q;
    logic [GAP_W-1:0] gap_q;
    logic [TO_W-1:0]  timeout_q;
    logic             trig_en_q;
    logic             trig_prev;

    logic             start_ok;
    logic             trig_edge;
    logic [CNT_W-1:0] burst_next;
    logic [TO_W-1:0]  to_next;
    logic [GAP_W-1:0] gap_load;
    logic [15:0]      ovf_next;
    logic             unused_stat;

    assign start_ok   = (cfg_burst_bytes != 32'd0) &&
                        ((cfg_burst_bytes % 32'(BYTES_PER_BEAT)) == 32'd0);
    assign trig_edge  = ext_trig & ~trig_prev;
    assign burst_next = (&burst_cnt) ? burst_cnt : burst_cnt + 1'b1;
    assign to_next    = to_cnt + 1'b1;
    // Gap lasts at least two cycles so the converter's registered reset lands.
    assign gap_load   = (gap_q < GAP_W'(2)) ? GAP_W'(1) : gap_q - 1'b1;
    assign ovf_next   = (&ovf_cnt) ? ovf_cnt : ovf_cnt + 1'b1;
    assign unused_stat = &{1'b0, conv_stat[31:2], conv_stat[0]};

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state          <= IDLE;
            arm_cnt        <= 1'b0;
            gap_cnt        <= '0;
            to_cnt         <= '0;
            num_bursts_q   <= '0;
            gap_q          <= '0;
            timeout_q      <= '0;
            trig_en_q      <= 1'b0;
            trig_prev      <= 1'b0;
            conv_ctrl      <= 32'd0;
            conv_num_bytes <= 32'd0;
            conv_trig      <= 1'b0;
            busy           <= 1'b0;
            run_done       <= 1'b0;
            err_cfg        <= 1'b0;
            err_timeout    <= 1'b0;
            burst_cnt      <= '0;
            ovf_cnt        <= '0;
        end else begin
            trig_prev <= ext_trig;
            run_done  <= 1'b0;
            err_cfg   <= 1'b0;
            if (cfg_abort && state != IDLE) begin
                state     <= IDLE;
                conv_ctrl <= 32'd0;
                conv_trig <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cfg_start) begin
                            if (start_ok) begin
                                num_bursts_q   <= cfg_num_bursts;
                                gap_q          <= cfg_gap;
                                timeout_q      <= cfg_timeout;
                                trig_en_q      <= cfg_ext_trig_en;
                                conv_num_bytes <= cfg_burst_bytes;
                                burst_cnt      <= '0;
                                ovf_cnt        <= '0;
                                err_timeout    <= 1'b0;
                                arm_cnt        <= 1'b1;
                                conv_ctrl      <= 32'd0;
                                busy           <= 1'b1;
                                state          <= ARM;
                            end else begin
                                err_cfg <= 1'b1;
                            end
                        end
                    end
                    ARM: begin
                        if (arm_cnt) begin
                            arm_cnt <= 1'b0;
                        end else if (trig_en_q) begin
                            conv_ctrl <= 32'd1;
                            state     <= WAIT_TRIG;
                        end else begin
                            conv_ctrl <= 32'd1;
                            conv_trig <= 1'b1;
                            to_cnt    <= '0;
                            state     <= RUN;
                        end
                    end
                    WAIT_TRIG: begin
                        if (trig_edge) begin
                            conv_trig <= 1'b1;
                            to_cnt    <= '0;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        to_cnt <= to_next;
                        if (conv_ovf) ovf_cnt <= ovf_next;
                        if (conv_stat[1]) begin
                            burst_cnt <= burst_next;
                            conv_ctrl <= 32'd0;
                            conv_trig <= 1'b0;
                            if (num_bursts_q != '0 && burst_next == num_bursts_q) begin
                                state <= DONE;
                            end else begin
                                gap_cnt <= gap_load;
                                state   <= GAP;
                            end
                        end else if (timeout_q != '0 && to_next == timeout_q) begin
                            err_timeout <= 1'b1;
                            conv_ctrl   <= 32'd0;
                            conv_trig   <= 1'b0;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    GAP: begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end else if (trig_en_q) begin
                            conv_ctrl <= 32'd1;
                            state     <= WAIT_TRIG;
                        end else begin
                            conv_ctrl <= 32'd1;
                            conv_trig <= 1'b1;
                            to_cnt    <= '0;
                            state     <= RUN;
                        end
                    end
                    DONE: begin
                        run_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        conv_ctrl <= 32'd0;
                        conv_trig <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/adi2axis_burst_sched.md
Name: adi2axis_burst_sched

Overview:
Sequencer for the adi2axis capture converter. It drives the converter's ctrl, num_bytes and trig inputs and monitors its stat and ovf outputs. It runs a programmed number of fixed-length DMA bursts, with an optional external-trigger wait and a programmable inter-burst gap, and aborts on timeout. It sits between the AXI-Lite register file and the converter, in the converter's clock domain.

Parameters:
BYTES_PER_BEAT, 8, bytes per AXIS beat; burst length must be a nonzero multiple of this.
CNT_W, 16, width of the burst-count config and the burst counter.
GAP_W, 16, width of the inter-burst gap counter.
TO_W, 24, width of the per-burst timeout counter.

Ports:
AXIS_ACLK  in  1  sole clock
AXIS_ARESET  in  1  asynchronous, active-high reset
cfg_start  in  1  one-cycle start pulse; ignored unless IDLE
cfg_abort  in  1  one-cycle abort pulse; wins over every other event
cfg_burst_bytes  in  32  bytes per burst
cfg_num_bursts  in  CNT_W  bursts per run; 0 = continuous until abort
cfg_gap  in  GAP_W  idle cycles between bursts
cfg_timeout  in  TO_W  max RUN cycles per burst; 0 = disabled
cfg_ext_trig_en  in  1  wait for ext_trig rising edge before each burst
ext_trig  in  1  external trigger, already synchronous to AXIS_ACLK
conv_ctrl  out  32  to converter ctrl: 0 = reset/hold, 1 = start
conv_num_bytes  out  32  to converter num_bytes
conv_trig  out  1  to converter trig
conv_stat  in  32  from converter stat; bit1 = done, bit0 = capture_en
conv_ovf  in  1  from converter ovf
busy  out  1  high in any state except IDLE
run_done  out  1  one-cycle pulse on normal completion
err_cfg  out  1  one-cycle pulse when a start is rejected
err_timeout  out  1  sticky; cleared by the next accepted start
burst_cnt  out  CNT_W  completed bursts in the current run
ovf_cnt  out  16  conv_ovf cycles seen in RUN; saturates at 0xFFFF; cleared on start

Behaviour:
- Reset values: state IDLE, conv_ctrl=0, conv_num_bytes=0, conv_trig=0, busy=0, run_done=0, err_cfg=0, err_timeout=0, burst_cnt=0, ovf_cnt=0, all internal counters 0.
- All outputs are registered. conv_ctrl is 1 only in WAIT_TRIG and RUN; conv_trig is 1 only in RUN.
- Start check: the start is rejected when cfg_burst_bytes==0 or cfg_burst_bytes % BYTES_PER_BEAT != 0. On rejection: err_cfg pulses the next cycle, state stays IDLE.
- On an accepted start: latch every cfg_* field; load conv_num_bytes; clear burst_cnt, ovf_cnt and err_timeout; go to ARM.
- IDLE: wait for cfg_start.
- ARM: hold conv_ctrl=0 for exactly 2 cycles so the converter's registered counter reset takes effect. Then go to WAIT_TRIG if ext_trig_en is latched, else go directly to RUN.
- WAIT_TRIG: stay until an ext_trig rising edge (previous sample 0, current 1), then go to RUN next cycle. A level held high since before entry does not count as an edge.
- RUN: the timeout counter increments each cycle.
  - If conv_stat[1]==1: burst_cnt += 1 (saturating). If num_bursts != 0 and the new burst_cnt == num_bursts, go to DONE; otherwise go to GAP.
  - Else if timeout != 0 and the counter reaches the timeout value: set err_timeout, go to IDLE, no run_done.
  - ovf_cnt increments each RUN cycle with conv_ovf=1.
- GAP: conv_ctrl=0 resets the converter for the next burst. Stay max(cfg_gap, 2) cycles, then go to WAIT_TRIG or RUN by the same rule as ARM. The gap counter counts down to 0.
- DONE: pulse run_done for 1 cycle, go to IDLE.
- Abort: cfg_abort in any non-IDLE state goes to IDLE next cycle; conv_ctrl and conv_trig drop to 0; burst_cnt and ovf_cnt are held for readback; no run_done. Abort in IDLE has no effect. If abort and done arrive in the same cycle, abort wins and the burst is not counted.
- cfg_start while busy is ignored and raises no err_cfg. cfg_* changes while busy have no effect until the next start.
- Continuous mode (num_bursts=0): burst_cnt saturates at all ones; the run ends only by abort or timeout.
- Reset asserted mid-run forces the reset values immediately and asynchronously.
- Latency: start to first conv_trig=1 is 3 cycles without external trigger (1 cycle start-to-ARM, plus 2 ARM cycles). conv_stat[1] seen to conv_ctrl=0 is 1 cycle.

Test Plan:
- bytes=64, bursts=2, gap=5, ext_trig_en=0 → conv_trig high 3 cycles after start; two RUN phases separated by 5 cycles of conv_ctrl=0; burst_cnt=2; run_done pulses once; busy drops the same cycle.
- bytes=60 start → err_cfg pulses once, busy stays 0; then bytes=0 → err_cfg pulses again.
- ext_trig_en=1, ext_trig held high before start, then dropped and raised 10 cycles later → RUN entered only after the rising edge; conv_trig stays 0 for the first 10 cycles.
- timeout=20, converter never asserts done → err_timeout set after 20 RUN cycles, state IDLE, no run_done; next valid start clears err_timeout.
- bursts=0, abort after 3 completed bursts, with abort coinciding with done → burst_cnt=3, conv_ctrl=0 next cycle, no run_done.
- conv_ovf high 7 cycles during RUN and 4 cycles in GAP → ovf_cnt=7; AXIS_ARESET pulsed mid-RUN → all outputs return to 0 immediately.
